// File: rtl/iopmp_pkg.sv
// IOPMP shared types: violation record image, record queue entry and offsets.
// Also provides the helper that packs a queue entry into the 32-bit record image.
package iopmp_pkg;

    localparam int IOPMP_SID_MAX  = 14;
    localparam int IOPMP_LEN_MAX  = 13;
    localparam int IOPMP_ADDR_MAX = 64;

    localparam logic [11:0] IOPMP_RCD_OFF      = 12'h018;
    localparam logic [11:0] IOPMP_RCD_ADDR_OFF = 12'h020;

    localparam int IOPMP_RCD_EXTRA_OVF  = 28;
    localparam int IOPMP_RCD_EXTRA_MORE = 29;

    typedef struct packed {
        logic                     illcgt;
        logic [2:0]               extra;
        logic [IOPMP_LEN_MAX-1:0] length;
        logic                     read;
        logic [IOPMP_SID_MAX-1:0] sid;
    } iopmp_rcd_t;

    typedef struct packed {
        logic                      illcgt;
        logic                      read;
        logic [IOPMP_LEN_MAX-1:0]  len;
        logic [IOPMP_SID_MAX-1:0]  sid;
        logic [IOPMP_ADDR_MAX-1:0] addr;
    } iopmp_rcd_entry_t;

    function automatic iopmp_rcd_t iopmp_rcd_pack(
        input logic                     illcgt,
        input logic                     read,
        input logic [IOPMP_LEN_MAX-1:0] len,
        input logic [IOPMP_SID_MAX-1:0] sid,
        input logic                     ovf,
        input logic                     more
    );
        logic [31:0] w;
        w = {illcgt, 3'b000, len, read, sid};
        w[IOPMP_RCD_EXTRA_OVF]  = ovf;
        w[IOPMP_RCD_EXTRA_MORE] = more;
        return iopmp_rcd_t'(w);
    endfunction

endpackage

// File: rtl/iopmp_prio_arb.sv
// Fixed-priority arbiter: lowest set index wins.
// lost flags any requester that asked in the same cycle but was not granted.
module iopmp_prio_arb #(
    parameter int N = 2
) (
    input  logic [N-1:0] valid,
    output logic [N-1:0] grant,
    output logic         lost
);

    // Two's-complement trick isolates the lowest set bit.
    assign grant = valid & (~valid + N'(1));
    assign lost  = |(valid & ~grant);

endmodule

// File: rtl/iopmp_rcd_queue.sv
// Multi-source IOPMP violation record queue with sticky overflow and irq.
// The head record is exposed as the 32-bit record image plus its address.
module iopmp_rcd_queue
    import iopmp_pkg::*;
#(
    parameter int NR_PORTS   = 2,
    parameter int DEPTH      = 4,
    parameter int SID_WIDTH  = 14,
    parameter int LEN_WIDTH  = 13,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           enable_i,
    input  logic                           clear_i,
    input  logic [NR_PORTS-1:0]            viol_valid_i,
    input  logic [NR_PORTS*SID_WIDTH-1:0]  viol_sid_i,
    input  logic [NR_PORTS-1:0]            viol_read_i,
    input  logic [NR_PORTS*LEN_WIDTH-1:0]  viol_len_i,
    input  logic [NR_PORTS-1:0]            viol_illcgt_i,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0] viol_addr_i,
    input  logic                           pop_i,
    output logic [31:0]                    rcd_o,
    output logic [ADDR_WIDTH-1:0]          rcd_addr_o,
    output logic                           rcd_valid_o,
    output logic [$clog2(DEPTH):0]         count_o,
    output logic                           ovf_o,
    output logic                           irq_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [NR_PORTS-1:0] grant;
    logic                lost;
    logic                any;

    iopmp_prio_arb #(
        .N(NR_PORTS)
    ) u_arb (
        .valid(viol_valid_i),
        .grant(grant),
        .lost (lost)
    );

    assign any = |viol_valid_i;

    iopmp_rcd_entry_t win;

    always_comb begin
        win = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            if (grant[p]) begin
                win.illcgt = viol_illcgt_i[p];
                win.read   = viol_read_i[p];
                win.len    = IOPMP_LEN_MAX'(viol_len_i[p*LEN_WIDTH +: LEN_WIDTH]);
                win.sid    = IOPMP_SID_MAX'(viol_sid_i[p*SID_WIDTH +: SID_WIDTH]);
                win.addr   = IOPMP_ADDR_MAX'(viol_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]);
            end
        end
    end

    iopmp_rcd_entry_t slots [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             irq;

    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             drop;
    logic [CW-1:0]    count_next;
    logic             ovf_next;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop_i & ~empty;

    // A full queue still accepts a push when the head retires in the same cycle.
    assign do_push = enable_i & any & (~full | do_pop);
    assign drop    = enable_i & any & full & ~do_pop;

    always_comb begin
        count_next = count;
        ovf_next   = ovf;
        if (clear_i) begin
            count_next = '0;
            ovf_next   = 1'b0;
        end else begin
            count_next = count + CW'(do_push) - CW'(do_pop);
            ovf_next   = ovf | (enable_i & lost) | drop;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            irq   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            if (clear_i) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (do_push) begin
                    slots[wptr] <= win;
                    wptr        <= wptr + PW'(1);
                end
                if (do_pop) begin
                    rptr <= rptr + PW'(1);
                end
            end
            count <= count_next;
            ovf   <= ovf_next;
            irq   <= (count_next != '0) | ovf_next;
        end
    end

    iopmp_rcd_entry_t head;
    iopmp_rcd_t       head_rcd;

    assign head     = slots[rptr];
    assign head_rcd = iopmp_rcd_pack(head.illcgt, head.read, head.len,
                                     head.sid, ovf, count > CW'(1));

    assign rcd_valid_o = ~empty;
    assign rcd_o       = empty ? 32'h0 : 32'(head_rcd);
    assign rcd_addr_o  = empty ? '0 : head.addr[ADDR_WIDTH-1:0];
    assign count_o     = count;
    assign ovf_o       = ovf;
    assign irq_o       = irq;

endmodule

// File: tb/tb_iopmp_rcd_queue.sv
// Bench for iopmp_rcd_queue: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_iopmp_rcd_queue;

    localparam int NP = 2;
    localparam int D  = 4;
    localparam int SW = 14;
    localparam int LW = 13;
    localparam int AW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic              enable_i;
    logic              clear_i;
    logic [NP-1:0]     viol_valid_i;
    logic [NP*SW-1:0]  viol_sid_i;
    logic [NP-1:0]     viol_read_i;
    logic [NP*LW-1:0]  viol_len_i;
    logic [NP-1:0]     viol_illcgt_i;
    logic [NP*AW-1:0]  viol_addr_i;
    logic              pop_i;
    logic [31:0]       rcd_o;
    logic [AW-1:0]     rcd_addr_o;
    logic              rcd_valid_o;
    logic [$clog2(D):0] count_o;
    logic              ovf_o;
    logic              irq_o;

    iopmp_rcd_queue #(
        .NR_PORTS  (NP),
        .DEPTH     (D),
        .SID_WIDTH (SW),
        .LEN_WIDTH (LW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable_i),
        .clear_i      (clear_i),
        .viol_valid_i (viol_valid_i),
        .viol_sid_i   (viol_sid_i),
        .viol_read_i  (viol_read_i),
        .viol_len_i   (viol_len_i),
        .viol_illcgt_i(viol_illcgt_i),
        .viol_addr_i  (viol_addr_i),
        .pop_i        (pop_i),
        .rcd_o        (rcd_o),
        .rcd_addr_o   (rcd_addr_o),
        .rcd_valid_o  (rcd_valid_o),
        .count_o      (count_o),
        .ovf_o        (ovf_o),
        .irq_o        (irq_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    typedef struct {
        bit        ill;
        bit        rd;
        bit [12:0] len;
        bit [13:0] sid;
        bit [63:0] addr;
    } rec_t;

    rec_t mq[$];
    bit   movf = 1'b0;
    bit   mirq = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            movf = 1'b0;
            mirq = 1'b0;
        end else begin
            if (clear_i) begin
                mq.delete();
                movf = 1'b0;
            end else begin
                if (pop_i && mq.size() > 0) void'(mq.pop_front());
                if (enable_i && viol_valid_i != '0) begin
                    int   w;
                    rec_t r;
                    w = 0;
                    for (int p = NP - 1; p >= 0; p--)
                        if (viol_valid_i[p]) w = p;
                    if ($countones(viol_valid_i) > 1) movf = 1'b1;
                    r.ill  = viol_illcgt_i[w];
                    r.rd   = viol_read_i[w];
                    r.len  = viol_len_i[w*LW +: LW];
                    r.sid  = viol_sid_i[w*SW +: SW];
                    r.addr = viol_addr_i[w*AW +: AW];
                    if (mq.size() < D) mq.push_back(r);
                    else movf = 1'b1;
                end
            end
            mirq = (mq.size() > 0) || movf;
        end
    end

    always @(negedge clk) begin
        logic [31:0] er;
        logic [63:0] ea;
        er = '0;
        ea = '0;
        if (mq.size() > 0) begin
            er = {mq[0].ill, 1'b0, mq.size() > 1, movf,
                  mq[0].len, mq[0].rd, mq[0].sid};
            ea = mq[0].addr;
        end
        chk("m_valid", rcd_valid_o, mq.size() > 0);
        chk("m_count", count_o, mq.size());
        chk("m_ovf", ovf_o, movf);
        chk("m_irq", irq_o, mirq);
        chk("m_rcd", rcd_o, er);
        chk("m_addr", rcd_addr_o, ea);
    end

    task automatic idle();
        viol_valid_i  = '0;
        viol_sid_i    = '0;
        viol_read_i   = '0;
        viol_len_i    = '0;
        viol_illcgt_i = '0;
        viol_addr_i   = '0;
    endtask

    task automatic setv(int p, int sid, bit rd, int len, bit ill, logic [63:0] a);
        viol_valid_i[p]        = 1'b1;
        viol_sid_i[p*SW +: SW] = SW'(sid);
        viol_read_i[p]         = rd;
        viol_len_i[p*LW +: LW] = LW'(len);
        viol_illcgt_i[p]       = ill;
        viol_addr_i[p*AW +: AW] = a;
    endtask

    task automatic tick(bit pop, bit clr);
        pop_i   = pop;
        clear_i = clr;
        @(negedge clk);
        pop_i   = 1'b0;
        clear_i = 1'b0;
        idle();
    endtask

    initial begin
        enable_i = 1'b0;
        clear_i  = 1'b0;
        pop_i    = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        chk("rst_count", count_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_valid", rcd_valid_o, 0);
        chk("rst_rcd", rcd_o, 0);
        rst_n    = 1'b1;
        enable_i = 1'b1;
        @(negedge clk);

        // single violation on port 0
        setv(0, 5, 1, 3, 0, 64'h8000_1000);
        tick(0, 0);
        chk("t1_valid", rcd_valid_o, 1);
        chk("t1_sid", rcd_o[13:0], 5);
        chk("t1_read", rcd_o[14], 1);
        chk("t1_len", rcd_o[27:15], 3);
        chk("t1_addr", rcd_addr_o, 64'h8000_1000);
        chk("t1_irq", irq_o, 1);
        chk("t1_count", count_o, 1);
        tick(1, 0);
        chk("t1_pop_valid", rcd_valid_o, 0);
        chk("t1_pop_irq", irq_o, 0);

        // two ports at once
        setv(0, 1, 0, 1, 0, 64'h100);
        setv(1, 2, 0, 1, 0, 64'h200);
        tick(0, 0);
        chk("t2_count", count_o, 1);
        chk("t2_ovf", ovf_o, 1);
        chk("t2_bit28", rcd_o[28], 1);
        chk("t2_bit29", rcd_o[29], 0);
        chk("t2_sid", rcd_o[13:0], 1);
        tick(0, 1);
        chk("t2_clr_ovf", ovf_o, 0);
        chk("t2_clr_irq", irq_o, 0);

        // port 1 alone wins, illcgt carried
        setv(1, 30, 0, 7, 1, 64'hABC0);
        tick(0, 0);
        chk("t2b_sid", rcd_o[13:0], 30);
        chk("t2b_ill", rcd_o[31], 1);
        chk("t2b_ovf", ovf_o, 0);
        tick(1, 0);

        // overflow on the fifth push
        for (int i = 1; i <= 5; i++) begin
            setv(0, i, i[0], i, 0, 64'(i) * 64'h1000);
            tick(0, 0);
        end
        chk("t3_count", count_o, 4);
        chk("t3_ovf", ovf_o, 1);
        chk("t3_more", rcd_o[29], 1);
        for (int i = 1; i <= 4; i++) begin
            chk("t3_order", rcd_o[13:0], 14'(i));
            tick(1, 0);
        end
        chk("t3_empty", rcd_valid_o, 0);
        chk("t3_irq_ovf", irq_o, 1);
        tick(0, 1);

        // full queue with simultaneous push and pop
        for (int i = 1; i <= 4; i++) begin
            setv(0, i, 0, 2, 0, 64'h40 + 64'(i));
            tick(0, 0);
        end
        chk("t4_full", count_o, 4);
        chk("t4_ovf0", ovf_o, 0);
        setv(0, 9, 1, 9, 0, 64'h9000);
        tick(1, 0);
        chk("t4_count", count_o, 4);
        chk("t4_ovf", ovf_o, 0);
        chk("t4_head", rcd_o[13:0], 2);
        for (int e = 2; e <= 4; e++) begin
            chk("t4_order", rcd_o[13:0], 14'(e));
            tick(1, 0);
        end
        chk("t4_last", rcd_o[13:0], 9);
        chk("t4_last_count", count_o, 1);
        setv(0, 7, 0, 1, 0, 64'h7000);
        tick(1, 0);
        chk("t4_pp1_sid", rcd_o[13:0], 7);
        chk("t4_pp1_count", count_o, 1);

        // clear with same-cycle push and pop
        setv(0, 11, 0, 1, 0, 64'hB000);
        tick(0, 0);
        setv(0, 12, 0, 1, 0, 64'hC000);
        tick(1, 1);
        chk("t5_count", count_o, 0);
        chk("t5_ovf", ovf_o, 0);
        chk("t5_rcd", rcd_o, 0);
        tick(0, 0);
        chk("t5_irq", irq_o, 0);

        // disabled capture, empty pop, pointer wrap
        enable_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setv(0, 3, 1, 1, 0, 64'h3000);
            tick(0, 0);
        end
        chk("t6_count", count_o, 0);
        chk("t6_ovf", ovf_o, 0);
        chk("t6_irq", irq_o, 0);
        tick(1, 0);
        chk("t6_pop_count", count_o, 0);
        chk("t6_pop_ovf", ovf_o, 0);
        enable_i = 1'b1;
        for (int i = 0; i < 2 * D; i++) begin
            setv(0, 20 + i, 0, i, 0, 64'h2000 + 64'(i));
            tick(0, 0);
            chk("t6_wrap_sid", rcd_o[13:0], 14'(20 + i));
            tick(1, 0);
            chk("t6_wrap_empty", rcd_valid_o, 0);
        end
        for (int i = 0; i < 3; i++) begin
            setv(0, 40 + i, 1, 4, 0, 64'h4000 + 64'(i));
            tick(0, 0);
        end
        for (int i = 0; i < 2 * D; i++) begin
            setv(0, 50 + i, 0, 5, 1, 64'h5000 + 64'(i));
            tick(1, 0);
        end
        chk("t6_mix_count", count_o, 3);
        chk("t6_mix_head", rcd_o[13:0], 55);
        repeat (3) tick(1, 0);
        chk("t6_mix_empty", rcd_valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
